mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that sits on the CPU data-memory store bus, beside dmem, and responds to the processor's stores.
- Decodes `address_to_mem`/`write_enable`, queues bytes in a 4-entry FIFO and serialises them 8N1 on `tx`.
- Provides a combinational read path (status/divisor) for loads.
- Intended as the first I/O device reachable from programs run in the top-level system.

---
 rtl/mmio_uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/mmio_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and the TX FSM state type.
package mmio_uart_pkg;

  localparam logic [31:0] OFF_TXDATA  = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
  localparam logic [31:0] OFF_DIVISOR = 32'h0000_0008;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_ACTIVE    = 2;
  localparam int unsigned ST_OVERFLOW  = 3;
  localparam int unsigned ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is dropped
// unless a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-bus UART transmitter: register decode, divisor/overflow state,
// a TX FIFO and an 8N1 serialiser with back-to-back frame chaining.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  input  logic        write_enable,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0] word_addr;
  logic        sel_txdata, sel_status, sel_divisor;
  logic        wr_txdata, wr_status, wr_divisor;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [2:0]  count3;

  logic [15:0] divisor;
  logic        overflow;

  tx_state_t   state, state_n;
  logic [15:0] bit_div, bit_div_n;
  logic [15:0] timer, timer_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        bit_done;

  logic        unused_bits;
  assign unused_bits = ^{address_to_mem[1:0], data_to_mem[31:16]};

  assign word_addr   = {address_to_mem[31:2], 2'b00};
  assign sel_txdata  = (word_addr == BASE_ADDR + OFF_TXDATA);
  assign sel_status  = (word_addr == BASE_ADDR + OFF_STATUS);
  assign sel_divisor = (word_addr == BASE_ADDR + OFF_DIVISOR);
  assign wr_txdata   = write_enable & sel_txdata;
  assign wr_status   = write_enable & sel_status;
  assign wr_divisor  = write_enable & sel_divisor;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (data_to_mem[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign count3 = 3'(fifo_count);

  always_ff @(posedge clk) begin
    if (!reset) begin
      divisor  <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_divisor)
        divisor <= (data_to_mem[15:0] == '0) ? 16'd1 : data_to_mem[15:0];
      if (wr_status)
        overflow <= 1'b0;
      else if (wr_txdata && fifo_full && !fifo_pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      bit_div <= '0;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      bit_div <= bit_div_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  assign bit_done = (timer == '0);

  always_comb begin
    state_n   = state;
    bit_div_n = bit_div;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    fifo_pop  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          timer_n   = bit_div - 16'd1;
          bit_idx_n = '0;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_n = {1'b0, shift[7:1]};
          timer_n = bit_div - 16'd1;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) fifo_pop = 1'b1;
          else state_n = IDLE;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Frame load is shared by IDLE and the final STOP clock so chained frames start gap-free.
    if (fifo_pop) begin
      state_n   = START;
      bit_div_n = divisor;
      timer_n   = divisor - 16'd1;
      shift_n   = fifo_dout;
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE) | ~fifo_empty;

  always_comb begin
    rd_data = '0;
    if (sel_status) begin
      rd_data[ST_FULL]              = fifo_full;
      rd_data[ST_EMPTY]             = fifo_empty;
      rd_data[ST_ACTIVE]            = (state != IDLE);
      rd_data[ST_OVERFLOW]          = overflow;
      rd_data[ST_COUNT_LSB +: 3]    = count3;
    end else if (sel_divisor) begin
      rd_data[15:0] = divisor;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: expected line levels come from a
// frame-level model (start bit, 8 data bits LSB first, stop bit, each div clocks).
module tb_mmio_uart_tx;

  localparam logic [31:0] TXD  = 32'h0000_0100;
  localparam logic [31:0] STS  = 32'h0000_0104;
  localparam logic [31:0] DIVR = 32'h0000_0108;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic        write_enable;
  logic [31:0] rd_data;
  logic        tx;
  logic        busy;

  int checks = 0;
  int passes = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_0100),
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (16'd16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .write_enable   (write_enable),
    .rd_data        (rd_data),
    .tx             (tx),
    .busy           (busy)
  );

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address_to_mem = a;
    data_to_mem    = d;
    write_enable   = 1'b1;
    @(negedge clk);
    write_enable   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address_to_mem = a;
    #1;
    d = rd_data;
  endtask

  task automatic model_frame(input logic [7:0] b, input int unsigned div);
    for (int unsigned k = 0; k < 10; k++) begin
      logic lvl;
      lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      repeat (div) exp_q.push_back(lvl);
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    reset = 1'b0; write_enable = 1'b0; address_to_mem = '0; data_to_mem = '0;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL reset_line tx=%b busy=%b exp tx=1 busy=0", tx, busy); else passes++;
    bus_read(STS, r);
    checks++; if (r !== 32'h2) $display("FAIL reset_status got=%h exp=%h", r, 32'h2); else passes++;
    bus_read(DIVR, r);
    checks++; if (r !== 32'd16) $display("FAIL reset_divisor got=%0d exp=16", r); else passes++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode;
    logic [31:0] r, a;
    bus_write(DIVR, 32'h0);
    bus_read(DIVR, r);
    checks++; if (r !== 32'd1) $display("FAIL div_zero got=%0d exp=1", r); else passes++;
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 32'h0000_010C : ($urandom | 32'h0000_1000);
      bus_read(a, r);
      checks++; if (r !== 32'h0) $display("FAIL out_of_window_read addr=%h got=%h exp=0", a, r); else passes++;
      bus_write(a, $urandom);
    end
    bus_read(DIVR, r);
    checks++; if (r !== 32'd1) $display("FAIL decode_divisor got=%0d exp=1", r); else passes++;
    bus_read(STS | 32'h3, r);
    checks++; if (r !== 32'h2) $display("FAIL decode_status got=%h exp=2", r); else passes++;
    bus_read(TXD | 32'h3, r);
    checks++; if (r !== 32'h0) $display("FAIL txdata_read got=%h exp=0", r); else passes++;
    bus_read(DIVR | 32'h2, r);
    checks++; if (r !== 32'd1) $display("FAIL divisor_low_bits got=%0d exp=1", r); else passes++;
    checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL decode_idle tx=%b busy=%b exp 1/0", tx, busy); else passes++;
  endtask

  task automatic test_single_byte;
    bus_write(DIVR, 32'd4);
    model_frame(8'hA5, 4);
    fork
      begin
        @(negedge clk);
        address_to_mem = TXD; data_to_mem = 32'hFFFF_FFA5; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
      end
      begin : mon
        int n;
        n = exp_q.size();
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b1) $display("FAIL single_latency tx=%b busy=%b exp 1/1", tx, busy); else passes++;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
          logic e;
          e = exp_q.pop_front();
          checks++; if (tx !== e) $display("FAIL single_line cyc=%0d tx=%b exp=%b", i, tx, e); else passes++;
          @(negedge clk);
        end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL single_end tx=%b busy=%b exp 1/0", tx, busy); else passes++;
      end
    join
  endtask

  task automatic test_back_to_back;
    bus_write(DIVR, 32'd2);
    model_frame(8'h01, 2); model_frame(8'h02, 2); model_frame(8'h03, 2);
    fork
      begin
        logic [31:0] r;
        @(negedge clk);
        address_to_mem = TXD; data_to_mem = 32'h01; write_enable = 1'b1;
        @(negedge clk); data_to_mem = 32'h02;
        @(negedge clk); data_to_mem = 32'h03;
        @(negedge clk); write_enable = 1'b0;
        bus_read(STS, r);
        checks++; if (r !== 32'h24) $display("FAIL b2b_status got=%h exp=%h", r, 32'h24); else passes++;
      end
      begin : mon
        int n;
        n = exp_q.size();
        checks++; if (n != 60) $display("FAIL b2b_length got=%0d exp=60", n); else passes++;
        repeat (3) @(negedge clk);
        for (int i = 0; i < n; i++) begin
          logic e;
          e = exp_q.pop_front();
          checks++; if (tx !== e) $display("FAIL b2b_line cyc=%0d tx=%b exp=%b", i, tx, e); else passes++;
          @(negedge clk);
        end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_end tx=%b busy=%b exp 1/0", tx, busy); else passes++;
      end
    join
  endtask

  task automatic test_overflow;
    logic [7:0] b [6];
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    bus_write(DIVR, 32'd100);
    model_frame(b[0], 100);
    for (int i = 1; i < 5; i++) model_frame(b[i], 1);
    fork
      begin
        logic [31:0] r;
        @(negedge clk);
        address_to_mem = TXD; data_to_mem = {24'h0, b[0]}; write_enable = 1'b1;
        for (int i = 1; i < 6; i++) begin
          @(negedge clk); data_to_mem = {24'h0, b[i]};
        end
        @(negedge clk); write_enable = 1'b0;
        bus_read(STS, r);
        checks++; if (r !== 32'h4D) $display("FAIL ovf_status got=%h exp=%h", r, 32'h4D); else passes++;
        address_to_mem = STS; data_to_mem = $urandom; write_enable = 1'b1;
        @(negedge clk); write_enable = 1'b0;
        bus_read(STS, r);
        checks++; if (r !== 32'h45) $display("FAIL ovf_clear got=%h exp=%h", r, 32'h45); else passes++;
        address_to_mem = DIVR; data_to_mem = 32'd1; write_enable = 1'b1;
        @(negedge clk); write_enable = 1'b0;
        bus_read(DIVR, r);
        checks++; if (r !== 32'd1) $display("FAIL ovf_divisor got=%0d exp=1", r); else passes++;
      end
      begin : mon
        int n;
        n = exp_q.size();
        repeat (3) @(negedge clk);
        for (int i = 0; i < n; i++) begin
          logic e;
          e = exp_q.pop_front();
          checks++; if (tx !== e) $display("FAIL ovf_line cyc=%0d tx=%b exp=%b", i, tx, e); else passes++;
          @(negedge clk);
        end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL ovf_end tx=%b busy=%b exp 1/0", tx, busy); else passes++;
      end
    join
  endtask

  task automatic test_divisor_midframe;
    logic [7:0] x, y;
    x = 8'($urandom); y = 8'($urandom);
    bus_write(DIVR, 32'd4);
    model_frame(x, 4); model_frame(y, 8);
    fork
      begin
        logic [31:0] r;
        @(negedge clk);
        address_to_mem = TXD; data_to_mem = {24'h0, x}; write_enable = 1'b1;
        @(negedge clk); data_to_mem = {24'h0, y};
        @(negedge clk); write_enable = 1'b0;
        repeat (8) @(negedge clk);
        address_to_mem = DIVR; data_to_mem = 32'd8; write_enable = 1'b1;
        @(negedge clk); write_enable = 1'b0;
        bus_read(DIVR, r);
        checks++; if (r !== 32'd8) $display("FAIL mid_divisor got=%0d exp=8", r); else passes++;
      end
      begin : mon
        int n;
        n = exp_q.size();
        repeat (3) @(negedge clk);
        for (int i = 0; i < n; i++) begin
          logic e;
          e = exp_q.pop_front();
          checks++; if (tx !== e) $display("FAIL mid_line cyc=%0d tx=%b exp=%b", i, tx, e); else passes++;
          @(negedge clk);
        end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL mid_end tx=%b busy=%b exp 1/0", tx, busy); else passes++;
      end
    join
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      int unsigned d, eff, nb;
      logic [7:0] b [4];
      logic [31:0] r;
      d   = $urandom_range(0, 5);
      eff = (d == 0) ? 1 : d;
      nb  = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      bus_write(DIVR, d);
      bus_read(DIVR, r);
      checks++; if (r !== eff) $display("FAIL rand_divisor it=%0d got=%0d exp=%0d", it, r, eff); else passes++;
      for (int unsigned i = 0; i < nb; i++) model_frame(b[i], eff);
      fork
        begin
          @(negedge clk);
          address_to_mem = TXD; data_to_mem = {24'h0, b[0]}; write_enable = 1'b1;
          for (int unsigned i = 1; i < nb; i++) begin
            @(negedge clk); data_to_mem = {24'h0, b[i]};
          end
          @(negedge clk); write_enable = 1'b0;
        end
        begin : mon
          int n;
          n = exp_q.size();
          repeat (3) @(negedge clk);
          for (int i = 0; i < n; i++) begin
            logic e;
            e = exp_q.pop_front();
            checks++; if (tx !== e) $display("FAIL rand_line it=%0d cyc=%0d tx=%b exp=%b", it, i, tx, e); else passes++;
            @(negedge clk);
          end
          checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL rand_end it=%0d tx=%b busy=%b exp 1/0", it, tx, busy); else passes++;
        end
      join
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] x, y;
    logic [31:0] r;
    x = 8'($urandom); y = 8'($urandom);
    bus_write(DIVR, 32'd4);
    model_frame(x, 4);
    @(negedge clk);
    address_to_mem = TXD; data_to_mem = {24'h0, x}; write_enable = 1'b1;
    @(negedge clk); data_to_mem = {24'h0, y};
    @(negedge clk); write_enable = 1'b0;
    // Samples 0..17 cover start and data bits 0..3; reset lands inside data bit 3.
    for (int i = 0; i < 18; i++) begin
      logic e;
      e = exp_q.pop_front();
      checks++; if (tx !== e) $display("FAIL rst_mid_line cyc=%0d tx=%b exp=%b", i, tx, e); else passes++;
      if (i == 17) reset = 1'b0;
      @(negedge clk);
    end
    exp_q.delete();
    checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL rst_mid_edge tx=%b busy=%b exp 1/0", tx, busy); else passes++;
    reset = 1'b1;
    bus_read(STS, r);
    checks++; if (r !== 32'h2) $display("FAIL rst_mid_status got=%h exp=2", r); else passes++;
    bus_read(DIVR, r);
    checks++; if (r !== 32'd16) $display("FAIL rst_mid_divisor got=%0d exp=16", r); else passes++;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL rst_mid_quiet cyc=%0d tx=%b busy=%b exp 1/0", i, tx, busy); else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_single_byte;
    test_back_to_back;
    test_overflow;
    test_divisor_midframe;
    test_random;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
